// File: rtl/regfile.sv
// ============================================================================
// regfile : 32x32 register file, one synchronous write port, two
//           combinational read ports, r0 hardwired to zero.  Rev 1.0
// ============================================================================
`default_nettype none

module decode5to32 (
  input  logic [4:0]  sel,
  output logic [31:0] onehot
);
  assign onehot = 32'b1 << sel;
endmodule

module regfile (
  input  logic        clock,
  input  logic        ctrl_reset,
  input  logic        ctrl_writeEnable,
  input  logic [4:0]  ctrl_writeReg,
  input  logic [31:0] data_writeReg,
  input  logic [4:0]  ctrl_readRegA,
  input  logic [4:0]  ctrl_readRegB,
  output logic [31:0] data_readRegA,
  output logic [31:0] data_readRegB
);

  logic [31:0] wr_dec;
  logic [31:0] rda_dec;
  logic [31:0] rdb_dec;
  logic [31:0] load_en;
  logic [31:0] reg_val [32];
  logic        unused_wr0;

  decode5to32 u_dec_wr (.sel(ctrl_writeReg), .onehot(wr_dec));
  decode5to32 u_dec_ra (.sel(ctrl_readRegA), .onehot(rda_dec));
  decode5to32 u_dec_rb (.sel(ctrl_readRegB), .onehot(rdb_dec));

  assign load_en    = wr_dec & {32{ctrl_writeEnable}};
  // r0 has no storage, so its load enable goes nowhere and writes vanish
  assign unused_wr0 = load_en[0];
  assign reg_val[0] = 32'h0;

  for (genvar i = 1; i < 32; i++) begin : g_reg
    logic [31:0] reg_d;
    logic [31:0] reg_q;

    always_comb begin
      reg_d = reg_q;
      if (load_en[i]) reg_d = data_writeReg;
    end

    always_ff @(posedge clock or posedge ctrl_reset) begin
      if (ctrl_reset) reg_q <= 32'h0;
      else            reg_q <= reg_d;
    end

    assign reg_val[i] = reg_q;
  end

  // One-hot AND-OR select: same behaviour as one enabled tristate bank per
  // port (exactly one driver active, never Z) without internal bidirectional nets.
  always_comb begin
    data_readRegA = 32'h0;
    data_readRegB = 32'h0;
    for (int k = 0; k < 32; k++) begin
      data_readRegA = data_readRegA | (reg_val[k] & {32{rda_dec[k]}});
      data_readRegB = data_readRegB | (reg_val[k] & {32{rdb_dec[k]}});
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_regfile.sv
// ============================================================================
// tb_regfile : directed table-driven checks plus multi-cycle corner cases.
// ============================================================================
`default_nettype none

module tb_regfile;

  logic        clock = 1'b0;
  logic        ctrl_reset;
  logic        ctrl_writeEnable;
  logic [4:0]  ctrl_writeReg;
  logic [31:0] data_writeReg;
  logic [4:0]  ctrl_readRegA;
  logic [4:0]  ctrl_readRegB;
  logic [31:0] data_readRegA;
  logic [31:0] data_readRegB;

  int tests  = 0;
  int failed = 0;

  regfile dut (
    .clock            (clock),
    .ctrl_reset       (ctrl_reset),
    .ctrl_writeEnable (ctrl_writeEnable),
    .ctrl_writeReg    (ctrl_writeReg),
    .data_writeReg    (data_writeReg),
    .ctrl_readRegA    (ctrl_readRegA),
    .ctrl_readRegB    (ctrl_readRegB),
    .data_readRegA    (data_readRegA),
    .data_readRegB    (data_readRegB)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        we;
    logic [4:0]  wreg;
    logic [31:0] wdata;
    logic [4:0]  ra;
    logic [4:0]  rb;
    logic [31:0] exp_a;
    logic [31:0] exp_b;
  } vec_t;

  vec_t vecs [10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic to_negedge();
    @(negedge clock);
  endtask

  initial begin
    // Each vector: drive at negedge, clock once, then read the ports.
    vecs[0] = '{1'b1, 5'd5,  32'hDEADBEEF, 5'd5,  5'd0,  32'hDEADBEEF, 32'h0};
    vecs[1] = '{1'b1, 5'd0,  32'hFFFFFFFF, 5'd0,  5'd0,  32'h0,        32'h0};
    vecs[2] = '{1'b1, 5'd7,  32'h00000007, 5'd7,  5'd5,  32'h00000007, 32'hDEADBEEF};
    vecs[3] = '{1'b0, 5'd7,  32'hA5A5A5A5, 5'd7,  5'd7,  32'h00000007, 32'h00000007};
    vecs[4] = '{1'b0, 5'd7,  32'hA5A5A5A5, 5'd7,  5'd7,  32'h00000007, 32'h00000007};
    vecs[5] = '{1'b0, 5'd7,  32'hA5A5A5A5, 5'd7,  5'd7,  32'h00000007, 32'h00000007};
    vecs[6] = '{1'b1, 5'd31, 32'hCAFEF00D, 5'd31, 5'd7,  32'hCAFEF00D, 32'h00000007};
    vecs[7] = '{1'b1, 5'd1,  32'h00000001, 5'd1,  5'd31, 32'h00000001, 32'hCAFEF00D};
    vecs[8] = '{1'b1, 5'd5,  32'h12345678, 5'd5,  5'd1,  32'h12345678, 32'h00000001};
    vecs[9] = '{1'b0, 5'd0,  32'h00000000, 5'd16, 5'd0,  32'h0,        32'h0};

    ctrl_reset       = 1'b1;
    ctrl_writeEnable = 1'b0;
    ctrl_writeReg    = 5'd0;
    data_writeReg    = 32'h0;
    ctrl_readRegA    = 5'd5;
    ctrl_readRegB    = 5'd31;
    #2;
    check("reset_a", data_readRegA, 32'h0);
    check("reset_b", data_readRegB, 32'h0);
    tick();
    to_negedge();
    ctrl_reset = 1'b0;

    for (int v = 0; v < 10; v++) begin
      ctrl_writeEnable = vecs[v].we;
      ctrl_writeReg    = vecs[v].wreg;
      data_writeReg    = vecs[v].wdata;
      ctrl_readRegA    = vecs[v].ra;
      ctrl_readRegB    = vecs[v].rb;
      tick();
      check($sformatf("vec%0d_a", v), data_readRegA, vecs[v].exp_a);
      check($sformatf("vec%0d_b", v), data_readRegB, vecs[v].exp_b);
      to_negedge();
    end

    // Reset pulse between edges clears immediately
    ctrl_writeEnable = 1'b1;
    ctrl_writeReg    = 5'd5;
    data_writeReg    = 32'hDEADBEEF;
    ctrl_readRegA    = 5'd5;
    ctrl_readRegB    = 5'd31;
    tick();
    ctrl_writeEnable = 1'b0;
    check("pre_rst_r5", data_readRegA, 32'hDEADBEEF);
    #1 ctrl_reset = 1'b1;
    #1;
    check("rst_clear_r5", data_readRegA, 32'h0);
    check("rst_clear_r31", data_readRegB, 32'h0);
    #1 ctrl_reset = 1'b0;
    #1;
    check("post_rst_r5", data_readRegA, 32'h0);
    to_negedge();

    // Full sweep
    for (int i = 1; i < 32; i++) begin
      ctrl_writeEnable = 1'b1;
      ctrl_writeReg    = 5'(i);
      data_writeReg    = 32'h1000_0000 + 32'(i);
      tick();
      to_negedge();
    end
    ctrl_writeEnable = 1'b0;
    for (int i = 0; i < 32; i++) begin
      ctrl_readRegA = 5'(i);
      ctrl_readRegB = 5'(31 - i);
      #1;
      check($sformatf("sweep_a%0d", i), data_readRegA, (i == 0) ? 32'h0 : 32'h1000_0000 + 32'(i));
      check($sformatf("sweep_b%0d", 31 - i), data_readRegB, (i == 31) ? 32'h0 : 32'h1000_0000 + 32'(31 - i));
    end
    to_negedge();

    // Read-during-write: old value before the edge, new after
    ctrl_writeEnable = 1'b1;
    ctrl_writeReg    = 5'd9;
    data_writeReg    = 32'h11;
    tick();
    to_negedge();
    data_writeReg = 32'h22;
    ctrl_readRegA = 5'd9;
    ctrl_readRegB = 5'd9;
    #1;
    check("rdw_before_a", data_readRegA, 32'h11);
    check("rdw_before_b", data_readRegB, 32'h11);
    tick();
    check("rdw_after_a", data_readRegA, 32'h22);
    check("rdw_after_b", data_readRegB, 32'h22);
    to_negedge();

    // Reset/write collision: edge during reset must not write
    ctrl_reset       = 1'b1;
    ctrl_writeEnable = 1'b1;
    ctrl_writeReg    = 5'd3;
    data_writeReg    = 32'h55;
    ctrl_readRegA    = 5'd3;
    ctrl_readRegB    = 5'd9;
    tick();
    check("coll_during_r3", data_readRegA, 32'h0);
    to_negedge();
    ctrl_reset       = 1'b0;
    ctrl_writeEnable = 1'b0;
    #1;
    check("coll_after_r3", data_readRegA, 32'h0);
    check("coll_after_r9", data_readRegB, 32'h0);
    to_negedge();

    // First edge after reset release performs a write
    ctrl_writeEnable = 1'b1;
    ctrl_writeReg    = 5'd3;
    data_writeReg    = 32'h77;
    tick();
    check("first_write_r3", data_readRegA, 32'h77);
    to_negedge();
    ctrl_writeEnable = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
